axi_up_mch_engine: RTL

Multi-channel memory-to-memory copy engine for the user-plugin subsystem, generalising the single-channel copy controller to NUM_CH independent channels. Each channel has its own source/destination/size, fixed-address modes and abort. Beats are interleaved round-robin over one shared read/write master port. It sits behind the plugin's register interface, which supplies per-channel configuration and command pulses. It returns per-channel status and one combined interrupt.

---
 rtl/axi_up_mch_engine_if.sv | 35 +++
 rtl/axi_up_mch_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_up_mch_engine_if.sv
// Shared read/write master bus of the multi-channel copy engine.
// Signal suffixes are named from the engine's point of view.
interface axi_up_mch_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  rd_req_valid_o;
    logic                  rd_req_ready_i;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic                  rd_rsp_valid_i;
    logic                  rd_rsp_ready_o;
    logic [DATA_WIDTH-1:0] rd_rsp_data_i;
    logic                  rd_rsp_err_i;
    logic                  wr_req_valid_o;
    logic                  wr_req_ready_i;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  wr_rsp_valid_i;
    logic                  wr_rsp_ready_o;
    logic                  wr_rsp_err_i;

    modport master (
        output rd_req_valid_o, rd_addr_o, rd_rsp_ready_o,
        output wr_req_valid_o, wr_addr_o, wr_data_o, wr_rsp_ready_o,
        input  rd_req_ready_i, rd_rsp_valid_i, rd_rsp_data_i, rd_rsp_err_i,
        input  wr_req_ready_i, wr_rsp_valid_i, wr_rsp_err_i
    );

    modport slave (
        input  rd_req_valid_o, rd_addr_o, rd_rsp_ready_o,
        input  wr_req_valid_o, wr_addr_o, wr_data_o, wr_rsp_ready_o,
        output rd_req_ready_i, rd_rsp_valid_i, rd_rsp_data_i, rd_rsp_err_i,
        output wr_req_ready_i, wr_rsp_valid_i, wr_rsp_err_i
    );
endinterface

// File: rtl/axi_up_mch_engine.sv
// Multi-channel memory-to-memory copy engine: one beat in flight at a time,
// channels served round-robin over a shared read/write master port.
module axi_up_mch_engine #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int SIZE_WIDTH = 15
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [NUM_CH*SIZE_WIDTH-1:0] size_i,
    input  logic [NUM_CH-1:0]            src_fixed_i,
    input  logic [NUM_CH-1:0]            dst_fixed_i,
    input  logic [NUM_CH-1:0]            int_en_i,
    input  logic [NUM_CH-1:0]            trigger_i,
    input  logic [NUM_CH-1:0]            abort_i,
    input  logic [NUM_CH-1:0]            clr_int_i,
    output logic [NUM_CH-1:0]            busy_o,
    output logic [NUM_CH-1:0]            int_pending_o,
    output logic [NUM_CH-1:0]            error_o,
    output logic                         int_o,
    axi_up_mch_engine_if.master          bus
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(BPB);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD_REQ,
        S_RD_RSP,
        S_WR_REQ,
        S_WR_RSP
    } state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]     busy_q, busy_d;
    logic [NUM_CH-1:0]     int_pend_q, int_pend_d;
    logic [NUM_CH-1:0]     error_q, error_d;
    logic [NUM_CH-1:0]     abort_pend_q, abort_pend_d;
    logic                  int_q;

    logic                  rd_req_valid_q, rd_rsp_ready_q;
    logic                  wr_req_valid_q, wr_rsp_ready_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] src_d [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_d [NUM_CH];
    logic [SIZE_WIDTH-1:0] rem_q [NUM_CH];
    logic [SIZE_WIDTH-1:0] rem_d [NUM_CH];
    logic [NUM_CH-1:0]     src_fix_q, src_fix_d;
    logic [NUM_CH-1:0]     dst_fix_q, dst_fix_d;

    logic                  pick_found;
    logic [CH_W-1:0]       pick_ch;
    logic                  in_beat;
    logic                  beat_end;
    logic                  beat_err;
    logic                  ch_abort;
    logic                  ch_int;
    logic [SIZE_WIDTH-1:0] new_beats;

    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return CH_W'(sum);
    endfunction

    assign in_beat = (state_q != S_IDLE) && (state_q != S_ARB);

    // Channels being aborted this cycle are not eligible for a new beat.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_found && busy_q[ch_add(rr_ptr_q, i)] && !abort_i[ch_add(rr_ptr_q, i)]) begin
                pick_found = 1'b1;
                pick_ch    = ch_add(rr_ptr_q, i);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        rr_ptr_d     = rr_ptr_q;
        busy_d       = busy_q;
        int_pend_d   = int_pend_q;
        error_d      = error_q;
        abort_pend_d = abort_pend_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        src_fix_d    = src_fix_q;
        dst_fix_d    = dst_fix_q;
        beat_end     = 1'b0;
        beat_err     = 1'b0;
        ch_abort     = 1'b0;
        ch_int       = 1'b0;
        new_beats    = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (clr_int_i[c]) begin
                int_pend_d[c] = 1'b0;
                error_d[c]    = 1'b0;
            end
            if (trigger_i[c] && !busy_q[c] && !abort_i[c]) begin
                new_beats    = size_i[c*SIZE_WIDTH +: SIZE_WIDTH] >> OFF;
                src_d[c]     = src_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                dst_d[c]     = dst_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                rem_d[c]     = new_beats;
                src_fix_d[c] = src_fixed_i[c];
                dst_fix_d[c] = dst_fixed_i[c];
                if (new_beats == '0) begin
                    if (int_en_i[c]) int_pend_d[c] = 1'b1;
                end else begin
                    busy_d[c]     = 1'b1;
                    int_pend_d[c] = 1'b0;
                    error_d[c]    = 1'b0;
                end
            end
            // The served channel must finish its beat before it can stop.
            if (abort_i[c] && busy_q[c]) begin
                if (in_beat && (cur_ch_q == CH_W'(c))) abort_pend_d[c] = 1'b1;
                else                                   busy_d[c]       = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: if (|busy_d) state_d = S_ARB;
            S_ARB: begin
                if (pick_found) begin
                    cur_ch_d  = pick_ch;
                    rd_addr_d = src_q[pick_ch];
                    state_d   = S_RD_REQ;
                end else if (!(|busy_d)) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: if (bus.rd_req_ready_i) state_d = S_RD_RSP;
            S_RD_RSP: begin
                if (bus.rd_rsp_valid_i) begin
                    if (bus.rd_rsp_err_i) begin
                        beat_end = 1'b1;
                        beat_err = 1'b1;
                    end else begin
                        wr_addr_d = dst_q[cur_ch_q];
                        wr_data_d = bus.rd_rsp_data_i;
                        state_d   = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: if (bus.wr_req_ready_i) state_d = S_WR_RSP;
            S_WR_RSP: begin
                if (bus.wr_rsp_valid_i) begin
                    beat_end = 1'b1;
                    beat_err = bus.wr_rsp_err_i;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (beat_end) begin
            rr_ptr_d = ch_add(cur_ch_q, 1);
            ch_abort = abort_pend_q[cur_ch_q] | abort_i[cur_ch_q];
            if (beat_err) begin
                error_d[cur_ch_q] = 1'b1;
                ch_int            = !ch_abort;
                busy_d[cur_ch_q]  = 1'b0;
            end else begin
                rem_d[cur_ch_q] = rem_q[cur_ch_q] - SIZE_WIDTH'(1);
                if (!src_fix_q[cur_ch_q]) src_d[cur_ch_q] = src_q[cur_ch_q] + ADDR_WIDTH'(BPB);
                if (!dst_fix_q[cur_ch_q]) dst_d[cur_ch_q] = dst_q[cur_ch_q] + ADDR_WIDTH'(BPB);
                if (rem_q[cur_ch_q] == SIZE_WIDTH'(1)) begin
                    ch_int           = !ch_abort;
                    busy_d[cur_ch_q] = 1'b0;
                end
                if (ch_abort) busy_d[cur_ch_q] = 1'b0;
            end
            if (ch_int && int_en_i[cur_ch_q]) int_pend_d[cur_ch_q] = 1'b1;
            abort_pend_d[cur_ch_q] = 1'b0;
            state_d = (|busy_d) ? S_ARB : S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= S_IDLE;
            cur_ch_q       <= '0;
            rr_ptr_q       <= '0;
            busy_q         <= '0;
            int_pend_q     <= '0;
            error_q        <= '0;
            abort_pend_q   <= '0;
            int_q          <= 1'b0;
            rd_req_valid_q <= 1'b0;
            rd_rsp_ready_q <= 1'b0;
            wr_req_valid_q <= 1'b0;
            wr_rsp_ready_q <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cur_ch_q       <= cur_ch_d;
            rr_ptr_q       <= rr_ptr_d;
            busy_q         <= busy_d;
            int_pend_q     <= int_pend_d;
            error_q        <= error_d;
            abort_pend_q   <= abort_pend_d;
            int_q          <= |int_pend_d;
            rd_req_valid_q <= (state_d == S_RD_REQ);
            rd_rsp_ready_q <= (state_d == S_RD_RSP);
            wr_req_valid_q <= (state_d == S_WR_REQ);
            wr_rsp_ready_q <= (state_d == S_WR_RSP);
            rd_addr_q      <= rd_addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    // NOTE: per-channel context is only read while its busy bit is set, and
    // busy is reset, so this storage carries no reset.
    always_ff @(posedge ACLK) begin
        src_q     <= src_d;
        dst_q     <= dst_d;
        rem_q     <= rem_d;
        src_fix_q <= src_fix_d;
        dst_fix_q <= dst_fix_d;
    end

    assign busy_o             = busy_q;
    assign int_pending_o      = int_pend_q;
    assign error_o            = error_q;
    assign int_o              = int_q;
    assign bus.rd_req_valid_o = rd_req_valid_q;
    assign bus.rd_addr_o      = rd_addr_q;
    assign bus.rd_rsp_ready_o = rd_rsp_ready_q;
    assign bus.wr_req_valid_o = wr_req_valid_q;
    assign bus.wr_addr_o      = wr_addr_q;
    assign bus.wr_data_o      = wr_data_q;
    assign bus.wr_rsp_ready_o = wr_rsp_ready_q;

endmodule
